// File: rtl/sample_recorder_pkg.sv
// ---------------------------------------------------------------------------
// Module  : sample_recorder_pkg
// Brief   : Shared types and tick-rate helpers for the sample recorder and
//           replayer, so both derive the same tick divisor.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package sample_recorder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RECORD = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Clock cycles per tick, never below 1 (1 means a tick every cycle).
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned tps);
    int unsigned d;
    d = (tps == 0) ? 1 : clk_hz / tps;
    return (d < 1) ? 1 : d;
  endfunction

  // Counter width needed to hold 0..div-1, at least one bit.
  function automatic int unsigned cnt_width(input int unsigned div);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) < 64'(div)) w = w + 1;
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sample_recorder_tick_divider.sv
// ---------------------------------------------------------------------------
// Module  : tick_divider
// Brief   : Free-running 0..DIV-1 counter; the wrap cycle is the tick.
//           'clear' holds the counter at zero and suppresses the tick.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tick_divider #(
  parameter int unsigned CLOCK_FREQ_HZ = 12000000,
  parameter int unsigned TICK_PER_SEC  = 100
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);
  import sample_recorder_pkg::*;

  localparam int unsigned          c_DIV  = calc_div(CLOCK_FREQ_HZ, TICK_PER_SEC);
  localparam int unsigned          c_CW   = cnt_width(c_DIV);
  localparam logic [c_CW-1:0]      c_LAST = c_CW'(c_DIV - 1);

  logic [c_CW-1:0] r_cnt;
  logic            w_wrap;

  assign w_wrap = (r_cnt == c_LAST);
  assign tick   = !clear && w_wrap;

  // Count up and wrap at DIV-1; cleared while idle so each take starts aligned.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_CW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/sample_recorder.sv
// ---------------------------------------------------------------------------
// Module  : sample_recorder
// Brief   : Captures a synchronized 8-bit input once per tick into sample RAM
//           at consecutive addresses and reports the take length.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module sample_recorder #(
  parameter int unsigned CLOCK_FREQ_HZ = 12000000,
  parameter int unsigned TICK_PER_SEC  = 100,
  parameter int unsigned ADDR_WIDTH    = 8,
  parameter int unsigned DEPTH         = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic [7:0]            sample_in,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [7:0]            wr_data,
  output logic [ADDR_WIDTH-1:0] length,
  output logic                  busy,
  output logic                  done
);
  import sample_recorder_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] c_LAST = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] c_ONE  = ADDR_WIDTH'(1);

  state_t                r_state;
  logic [7:0]            r_sync1;
  logic [7:0]            r_sync2;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [7:0]            r_wr_data;
  logic [ADDR_WIDTH-1:0] r_length;
  logic                  r_busy;
  logic                  r_done;
  logic                  w_clear;
  logic                  w_tick;
  logic                  w_last;

  // Counter runs only while recording, so the first tick lands DIV cycles in.
  assign w_clear = (r_state != ST_RECORD);
  assign w_last  = (r_ptr == c_LAST);

  tick_divider #(
    .CLOCK_FREQ_HZ (CLOCK_FREQ_HZ),
    .TICK_PER_SEC  (TICK_PER_SEC)
  ) u_tick_divider (
    .clk   (clk),
    .reset (reset),
    .clear (w_clear),
    .tick  (w_tick)
  );

  // Two-flop synchronizer for the asynchronous sample source.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= sample_in;
      r_sync2 <= r_sync1;
    end
  end

  // Take control FSM with registered RAM-write and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_length  <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        ST_RECORD: begin
          if (w_tick) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_ptr;
            r_wr_data <= r_sync2;
            r_ptr     <= r_ptr + c_ONE;
            r_length  <= r_ptr + c_ONE;
          end
          // A stop on a tick cycle still commits that tick's sample above.
          if (stop || (w_tick && w_last)) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          // IDLE and DONE both wait for start; length holds until then.
          if (start) begin
            r_state  <= ST_RECORD;
            r_busy   <= 1'b1;
            r_ptr    <= '0;
            r_length <= '0;
          end
        end
      endcase
    end
  end

  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;
  assign length  = r_length;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

`default_nettype wire

// File: tb/tb_sample_recorder.sv
// ---------------------------------------------------------------------------
// Module  : tb_sample_recorder
// Brief   : Directed self-checking bench for sample_recorder (DIV=4, DEPTH=5).
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sample_recorder;

  localparam int AW = 8;

  logic          clk;
  logic          reset;
  logic          start;
  logic          stop;
  logic [7:0]    sample_in;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic [AW-1:0] length;
  logic          busy;
  logic          done;

  int checks;
  int errors;
  int cyc;

  // Observations of the current take
  int       n_wr;
  int       n_done;
  int       n_b2b;
  int       done_cyc;
  logic     prev_wr;
  int       t_start;
  logic [AW-1:0] obs_addr [0:15];
  logic [7:0]    obs_data [0:15];
  int            obs_cyc  [0:15];

  sample_recorder #(
    .CLOCK_FREQ_HZ (12),
    .TICK_PER_SEC  (3),
    .ADDR_WIDTH    (AW),
    .DEPTH         (5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .sample_in (sample_in),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .length    (length),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic clear_obs();
    n_wr    = 0;
    n_done  = 0;
    n_b2b   = 0;
    done_cyc = -1;
    prev_wr = 1'b0;
    sample_in = 8'h10;
  endtask

  // Advance to the next falling edge and log writes/done pulses; the sample
  // source ramps after each observed write so every tick sees a fresh value.
  task automatic step();
    @(negedge clk);
    if (wr_en) begin
      if (prev_wr) n_b2b++;
      if (n_wr < 16) begin
        obs_addr[n_wr] = wr_addr;
        obs_data[n_wr] = wr_data;
        obs_cyc[n_wr]  = cyc;
      end
      n_wr++;
      sample_in = 8'h10 + 8'(n_wr);
    end
    prev_wr = wr_en;
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    t_start = cyc + 1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_writes(input int target);
    for (int i = 0; i < 80; i++) begin
      if (n_wr >= target) break;
      step();
    end
    checks++;
    if (n_wr < target) begin
      errors++;
      $display("FAIL wait_writes: saw %0d writes, required %0d", n_wr, target);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if ({wr_en, wr_addr, wr_data, length, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got en=%b addr=%h data=%h len=%0d busy=%b done=%b, required all 0",
               wr_en, wr_addr, wr_data, length, busy, done);
    end
    reset = 1'b0;
    clear_obs();
    // stop outside RECORD must be ignored
    stop = 1'b1;
    step();
    stop = 1'b0;
    for (int i = 0; i < 20; i++) step();
    checks++;
    if (n_wr !== 0 || n_done !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_quiet: writes=%0d done=%0d busy=%b, required 0/0/0", n_wr, n_done, busy);
    end
  endtask

  task automatic test_stop_after_three();
    clear_obs();
    pulse_start();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_on_start: got %b, required 1", busy);
    end
    wait_writes(3);
    stop = 1'b1;
    step();
    stop = 1'b0;
    for (int i = 0; i < 12; i++) step();
    checks++;
    if (n_wr !== 3) begin
      errors++;
      $display("FAIL stop3_count: got %0d writes, required 3", n_wr);
    end
    checks++;
    if (obs_cyc[0] - t_start !== 4) begin
      errors++;
      $display("FAIL stop3_first_latency: got %0d cycles, required 4", obs_cyc[0] - t_start);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs_addr[k] !== AW'(k) || obs_data[k] !== 8'h10 + 8'(k)) begin
        errors++;
        $display("FAIL stop3_write%0d: got addr=%0d data=%h, required addr=%0d data=%h",
                 k, obs_addr[k], obs_data[k], k, 8'h10 + 8'(k));
      end
    end
    for (int k = 1; k < 3; k++) begin
      checks++;
      if (obs_cyc[k] - obs_cyc[k-1] !== 4) begin
        errors++;
        $display("FAIL stop3_spacing%0d: got %0d cycles, required 4", k, obs_cyc[k] - obs_cyc[k-1]);
      end
    end
    checks++;
    if (n_done !== 1 || done_cyc !== obs_cyc[2] + 1 || length !== AW'(3) || busy !== 1'b0) begin
      errors++;
      $display("FAIL stop3_end: got done=%0d@%0d len=%0d busy=%b, required done=1@%0d len=3 busy=0",
               n_done, done_cyc, length, busy, obs_cyc[2] + 1);
    end
  endtask

  task automatic test_depth_limit();
    clear_obs();
    pulse_start();
    wait_writes(2);
    // start while recording must not restart the take
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 40; i++) step();
    checks++;
    if (n_wr !== 5) begin
      errors++;
      $display("FAIL depth_count: got %0d writes, required 5", n_wr);
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (obs_addr[k] !== AW'(k) || obs_data[k] !== 8'h10 + 8'(k)) begin
        errors++;
        $display("FAIL depth_write%0d: got addr=%0d data=%h, required addr=%0d data=%h",
                 k, obs_addr[k], obs_data[k], k, 8'h10 + 8'(k));
      end
    end
    checks++;
    if (n_done !== 1 || length !== AW'(5) || busy !== 1'b0 || n_b2b !== 0) begin
      errors++;
      $display("FAIL depth_end: got done=%0d len=%0d busy=%b b2b=%0d, required 1/5/0/0",
               n_done, length, busy, n_b2b);
    end
  endtask

  task automatic test_stop_on_tick();
    clear_obs();
    pulse_start();
    wait_writes(1);
    // Second tick is the cycle ending four edges after the first write
    step(); step(); step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    for (int i = 0; i < 12; i++) step();
    checks++;
    if (n_wr !== 2 || n_done !== 1 || done_cyc !== obs_cyc[1]) begin
      errors++;
      $display("FAIL stop_tick: got writes=%0d done=%0d done@%0d wr2@%0d, required 2 writes, 1 done on same cycle",
               n_wr, n_done, done_cyc, obs_cyc[1]);
    end
    checks++;
    if (obs_addr[1] !== AW'(1) || obs_data[1] !== 8'h11 || length !== AW'(2)) begin
      errors++;
      $display("FAIL stop_tick_data: got addr=%0d data=%h len=%0d, required 1/11/2",
               obs_addr[1], obs_data[1], length);
    end
  endtask

  task automatic test_zero_length();
    clear_obs();
    pulse_start();
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    for (int i = 0; i < 12; i++) step();
    checks++;
    if (n_wr !== 0 || n_done !== 1 || length !== AW'(0) || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_len: got writes=%0d done=%0d len=%0d busy=%b, required 0/1/0/0",
               n_wr, n_done, length, busy);
    end
  endtask

  task automatic test_reset_mid_take();
    clear_obs();
    pulse_start();
    wait_writes(2);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (length !== AW'(0) || busy !== 1'b0 || wr_en !== 1'b0) begin
      errors++;
      $display("FAIL midreset_state: got len=%0d busy=%b en=%b, required 0/0/0", length, busy, wr_en);
    end
    for (int i = 0; i < 20; i++) step();
    checks++;
    if (n_wr !== 2 || n_done !== 0) begin
      errors++;
      $display("FAIL midreset_quiet: got writes=%0d done=%0d, required 2/0", n_wr, n_done);
    end
    clear_obs();
    pulse_start();
    wait_writes(1);
    checks++;
    if (obs_addr[0] !== AW'(0) || obs_data[0] !== 8'h10 || length !== AW'(1)) begin
      errors++;
      $display("FAIL midreset_restart: got addr=%0d data=%h len=%0d, required 0/10/1",
               obs_addr[0], obs_data[0], length);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    reset     = 1'b1;
    start     = 1'b0;
    stop      = 1'b0;
    sample_in = 8'h00;
    clear_obs();
    test_reset();
    test_stop_after_three();
    test_depth_limit();
    test_stop_on_tick();
    test_zero_length();
    test_reset_mid_take();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sample_recorder.md
Name: sample_recorder

Overview:
- Capture stage directly upstream of the replayer.
- Samples an 8-bit input at a fixed tick rate and writes each sample into the shared sample RAM at consecutive addresses.
- Reports the number of samples captured as `length`, which drives the replayer's `limit` input.
- Tick timing uses the same CLOCK_FREQ_HZ/TICK_PER_SEC scheme as the replayer, so playback reproduces capture timing.

Parameters:
CLOCK_FREQ_HZ, 12000000, system clock frequency in Hz
TICK_PER_SEC, 100, samples captured per second
ADDR_WIDTH, 8, RAM address width; also the width of `length`
DEPTH, 255, max samples per take; must be ≤ 2**ADDR_WIDTH-1 so `length` never overflows

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse: begin a new take
stop  in  1  one-cycle pulse: end the current take
sample_in  in  8  asynchronous sample source (switches/pins)
wr_en  out  1  RAM write strobe, one cycle per sample
wr_addr  out  ADDR_WIDTH  RAM write address
wr_data  out  8  RAM write data
length  out  ADDR_WIDTH  samples written in current/last take
busy  out  1  high while recording
done  out  1  one-cycle pulse when a take ends

Behaviour:
- Tick divisor: DIV = CLOCK_FREQ_HZ/TICK_PER_SEC (integer), clamped to a minimum of 1. DIV=1 means one tick every cycle.
- Input sync: `sample_in` passes through a 2-flop synchronizer. The sampled value is the synchronizer output on the tick cycle.
- Reset: state IDLE. wr_en=0, wr_addr=0, wr_data=0, length=0, busy=0, done=0. Tick counter and pointer cleared.
- Reset mid-take: abandons the take with no done pulse. `length` returns to 0.
- States: IDLE, RECORD, DONE.
- IDLE or DONE, start=1: next cycle enter RECORD with busy=1, tick counter=0, pointer=0, length=0.
- RECORD, tick counter: counts 0..DIV-1 and wraps. The wrap cycle is a tick.
  - First tick occurs DIV cycles after entering RECORD.
- RECORD, on a tick, registered one cycle later:
  - wr_en=1, wr_addr=pointer, wr_data=synced sample.
  - pointer increments; length=pointer+1.
- RECORD, DEPTH reached: after the write with pointer==DEPTH-1, next cycle enter DONE.
- RECORD, stop=1: next cycle enter DONE.
  - If stop coincides with a tick, that sample is still written (wr_en pulses in the same cycle DONE is entered).
- Entering DONE: done=1 for exactly one cycle, busy=0. `length` holds until the next start or reset.
- start while in RECORD: ignored. stop outside RECORD: ignored.
- start and stop in the same cycle: from IDLE/DONE, start wins; in RECORD, stop wins.
- Zero-length take: stop before the first tick gives length=0 with done pulsed.
- wr_en is never high in IDLE or for more than one consecutive cycle when DIV>1.
- Outputs wr_addr/wr_data hold their last values when wr_en=0.

Decomposition:
- Shared package (e.g. sample_pkg): state encoding (IDLE/RECORD/DONE); localparam function computing the clamped DIV from CLOCK_FREQ_HZ/TICK_PER_SEC. The replayer uses the same function so both rates match.
- Natural sub-module: tick_divider (params CLOCK_FREQ_HZ, TICK_PER_SEC; ports clk, reset, clear, tick), reusable by the replayer.
- Synchronizer is inline flops; no separate module.

Test Plan (CLOCK_FREQ_HZ=12, TICK_PER_SEC=3 → DIV=4, DEPTH=5):
- Reset held 3 cycles → all outputs 0, busy=0. After release, no wr_en for 20 cycles.
- start pulse, sample_in ramps 8'h10,8'h11,… per tick, stop after 3 ticks → exactly 3 wr_en pulses spaced 4 cycles apart; addrs 0,1,2; wr_data = synced values; done once; length=3; busy low.
- start, no stop → 5 writes at addrs 0..4, then auto DONE; length=5; done pulses once; no 6th write.
- stop asserted on the same cycle as the 2nd tick → 2 writes, the 2nd coinciding with DONE entry; length=2.
- start, then stop after 2 cycles → zero writes; length=0; done pulses.
- Reset asserted mid-take after 2 writes → no further wr_en, no done, length=0. A new start records from addr 0.
